// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath constants.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int ZERO_REG = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write vector; issue sets, write-back clears.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG = cpu_pkg::NREG,
  parameter bit ZERO_R0 = 1'b1,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iss,
  input  logic [AW-1:0]   iss_rd,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  output logic [NREG-1:0] busy
);
  logic [NREG-1:0] nxt;
  // A new issue supersedes an older pending write to the same register.
  always_comb begin
    nxt = busy;
    for (int r = 0; r < NREG; r++)
      nxt[r] = (iss && iss_rd == AW'(r)) ? 1'b1 :
               ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r))) ? 1'b0 : busy[r];
    if (ZERO_R0) nxt[ZERO_REG] = 1'b0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) busy <= '0;
    else busy <= nxt;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: dual-write register file with write-to-read bypass and RAW hazard flags.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN,
  parameter int NREG = cpu_pkg::NREG,
  parameter int NRD = 2,
  parameter bit ZERO_R0 = 1'b1,
  localparam int AW = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rhaz,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                iss,
  input  logic [AW-1:0]       iss_rd,
  output logic [NREG-1:0]     busy
);
  logic [XLEN-1:0] mem [NREG];
  logic ok0, ok1;
  assign ok0 = we0 && !(ZERO_R0 && wa0 == AW'(ZERO_REG));
  assign ok1 = we1 && !(ZERO_R0 && wa1 == AW'(ZERO_REG));
  // Port 1 assigned last so a same-address load write-back wins.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      for (int r = 0; r < NREG; r++) mem[r] <= '0;
    end else begin
      if (ok0) mem[wa0] <= wd0;
      if (ok1) mem[wa1] <= wd1;
    end
  regfile_scoreboard #(.NREG(NREG), .ZERO_R0(ZERO_R0)) u_sb (
    .clock(clock), .reset(reset), .iss(iss), .iss_rd(iss_rd),
    .we0(we0), .wa0(wa0), .we1(we1), .wa1(wa1), .busy(busy)
  );
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic z, h0, h1;
    assign a = ra[i*AW +: AW];
    assign z = ZERO_R0 && a == AW'(ZERO_REG);
    assign h1 = we1 && wa1 == a;
    assign h0 = we0 && wa0 == a;
    assign rd[i*XLEN +: XLEN] = (reset || z) ? '0 : h1 ? wd1 : h0 ? wd0 : mem[a];
    assign rhaz[i] = !reset && !z && busy[a] && !h1 && !h0;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and random checks of regfile_sb against an array reference model.
module tb_regfile_sb;
  logic clock = 1'b0, reset;
  always #5 clock = ~clock;
  logic [9:0] ra;
  logic [63:0] rd;
  logic [1:0] rhaz;
  logic we0, we1, iss;
  logic [4:0] wa0, wa1, iss_rd;
  logic [31:0] wd0, wd1, busy;
  logic [11:0] rab;
  logic [95:0] rdb;
  logic [2:0] rhazb;
  logic we0b, we1b, issb;
  logic [3:0] wa0b, wa1b, iss_rdb;
  logic [31:0] wd0b, wd1b;
  logic [15:0] busyb;
  int total = 0, bad = 0;
  logic [31:0] m [32];
  bit b [32];

  regfile_sb dut (
    .clock(clock), .reset(reset), .ra(ra), .rd(rd), .rhaz(rhaz),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss(iss), .iss_rd(iss_rd), .busy(busy)
  );
  regfile_sb #(.NREG(16), .NRD(3), .ZERO_R0(1'b0)) dutb (
    .clock(clock), .reset(reset), .ra(rab), .rd(rdb), .rhaz(rhazb),
    .we0(we0b), .wa0(wa0b), .wd0(wd0b), .we1(we1b), .wa1(wa1b), .wd1(wd1b),
    .iss(issb), .iss_rd(iss_rdb), .busy(busyb)
  );

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] bvec();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = b[r];
    return v;
  endfunction

  // Reads must equal what the register holds once this cycle's writes land.
  task automatic apply(input bit e0, input logic [4:0] a0, input logic [31:0] d0,
                       input bit e1, input logic [4:0] a1, input logic [31:0] d1,
                       input bit is, input logic [4:0] ir,
                       input logic [4:0] r0, input logic [4:0] r1);
    logic [31:0] nm [32];
    logic [4:0] rr [2];
    we0 = e0; wa0 = a0; wd0 = d0; we1 = e1; wa1 = a1; wd1 = d1;
    iss = is; iss_rd = ir; ra = {r1, r0};
    #1;
    nm = m;
    if (e0 && a0 != 0) nm[a0] = d0;
    if (e1 && a1 != 0) nm[a1] = d1;
    rr[0] = r0; rr[1] = r1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd%0d_r%0d", k, rr[k]), {32'd0, rd[k*32 +: 32]},
          {32'd0, (rr[k] == 0) ? 32'd0 : nm[rr[k]]});
      chk($sformatf("rhaz%0d_r%0d", k, rr[k]), {63'd0, rhaz[k]},
          {63'd0, rr[k] != 0 && b[rr[k]] && !(e0 && a0 == rr[k]) && !(e1 && a1 == rr[k])});
    end
    @(posedge clock);
    m = nm;
    if (e0) b[a0] = 0;
    if (e1) b[a1] = 0;
    if (is) b[ir] = 1;
    b[0] = 0;
    #1;
    chk("busy", {32'd0, busy}, {32'd0, bvec()});
    we0 = 0; we1 = 0; iss = 0;
  endtask

  initial begin
    reset = 1;
    ra = 0; we0 = 0; wa0 = 0; wd0 = 0; we1 = 1; wa1 = 5'd4; wd1 = 32'h77; iss = 0; iss_rd = 0;
    rab = 0; we0b = 0; wa0b = 0; wd0b = 0; we1b = 0; wa1b = 0; wd1b = 0; issb = 0; iss_rdb = 0;
    ra = {5'd0, 5'd4};
    for (int r = 0; r < 32; r++) begin m[r] = 0; b[r] = 0; end
    #3;
    chk("reset_rd0", {32'd0, rd[31:0]}, 64'd0);
    chk("reset_busy", {32'd0, busy}, 64'd0);
    we1 = 0;
    #4 reset = 0;
    @(posedge clock); #1;
    apply(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1, 5'd10, 5'd1, 5'd2);
    apply(0, 0, 0, 0, 0, 0, 1, 5'd12, 5'd5, 5'd10);
    // Asynchronous reset in mid-cycle drops everything immediately.
    #2 reset = 1;
    ra = {5'd10, 5'd5}; we1 = 1; wa1 = 5'd5; wd1 = 32'h99;
    #1;
    chk("midreset_rd0", {32'd0, rd[31:0]}, 64'd0);
    chk("midreset_rhaz", {62'd0, rhaz}, 64'd0);
    chk("midreset_busy", {32'd0, busy}, 64'd0);
    for (int r = 0; r < 32; r++) begin m[r] = 0; b[r] = 0; end
    we1 = 0;
    #1 reset = 0;
    @(posedge clock); #1;
    chk("post_reset_busy", {32'd0, busy}, 64'd0);
    apply(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5'd1, 5'd2);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd0);
    apply(0, 0, 0, 1, 5'd0, 32'h1234, 1, 5'd0, 5'd0, 5'd0);
    apply(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 0, 0, 5'd0, 5'd7);
    apply(0, 0, 0, 0, 0, 0, 1, 5'd3, 5'd7, 5'd7);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 5'd7);
    apply(1, 5'd3, 32'h55, 0, 0, 0, 0, 0, 5'd3, 5'd3);
    apply(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd3);
    apply(0, 0, 0, 1, 5'd9, 32'hABCD, 1, 5'd9, 5'd9, 5'd0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9);
    apply(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd9);
    apply(1, 5'd9, 32'h1, 0, 0, 0, 0, 0, 5'd9, 5'd9);
    for (int n = 0; n < 300; n++)
      apply($urandom_range(0, 1) == 1, 5'($urandom), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom),
            5'($urandom), 5'($urandom));
    // Second configuration: 16 registers, 3 read ports, register 0 ordinary.
    we0b = 1; wa0b = 4'd0; wd0b = 32'hA5; issb = 1; iss_rdb = 4'd15; rab = {4'd2, 4'd1, 4'd0};
    #1;
    chk("b_r0_bypass", {32'd0, rdb[31:0]}, 64'hA5);
    @(posedge clock); #1;
    we0b = 1; wa0b = 4'd1; wd0b = 32'hB1; we1b = 1; wa1b = 4'd2; wd1b = 32'hC2;
    issb = 1; iss_rdb = 4'd0;
    chk("b_busy15", {48'd0, busyb}, 64'h8000);
    #1;
    chk("b_rd0", {32'd0, rdb[31:0]}, 64'hA5);
    chk("b_rd1", {32'd0, rdb[63:32]}, 64'hB1);
    chk("b_rd2", {32'd0, rdb[95:64]}, 64'hC2);
    @(posedge clock); #1;
    we0b = 0; we1b = 0; issb = 0; rab = {4'd15, 4'd0, 4'd2};
    #1;
    chk("b_busy0", {48'd0, busyb}, 64'h8001);
    chk("b_rhaz", {61'd0, rhazb}, 64'h6);
    chk("b_st0", {32'd0, rdb[31:0]}, 64'hC2);
    chk("b_st1", {32'd0, rdb[63:32]}, 64'hA5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
